// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory arbiter: FSM states, requester IDs and
// the ID-to-ack decode used when the access completes.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] ID_L = 2'd0;
    localparam logic [1:0] ID_D = 2'd1;
    localparam logic [1:0] ID_F = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        DONE  = ST_DONE
    } state_t;

    typedef logic [1:0] req_id_t;

    // Ack vector bit order is {F, D, L}
    function automatic logic [2:0] id_onehot(input req_id_t id);
        return 3'b001 << id;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-controller-side signals of the arbiter.
// The slave modport is the arbiter; master is the requesters plus memory.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              reqL, reqD, reqF;
    logic [ADDR_W-1:0] addrL, addrD, addrF;
    logic [DATA_W-1:0] wdataL, wdataD, wdataF;
    logic              weL, weD, weF;
    logic              ackL, ackD, ackF;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic [ADDR_W-1:0] addressVirt;
    logic [DATA_W-1:0] dataInVirt;
    logic              wEnVirt;
    logic [DATA_W-1:0] dataOutVirt;

    modport slave (
        input  reqL, reqD, reqF, addrL, addrD, addrF,
        input  wdataL, wdataD, wdataF, weL, weD, weF, dataOutVirt,
        output ackL, ackD, ackF, rdata, busy,
        output addressVirt, dataInVirt, wEnVirt
    );

    modport master (
        output reqL, reqD, reqF, addrL, addrD, addrF,
        output wdataL, wdataD, wdataF, weL, weD, weF, dataOutVirt,
        input  ackL, ackD, ackF, rdata, busy,
        input  addressVirt, dataInVirt, wEnVirt
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: L has absolute priority, D/F alternate
// on a tie with the last-served one losing.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic    req_l,
    input  logic    req_d,
    input  logic    req_f,
    input  logic    last_d,
    output logic    gnt_vld,
    output req_id_t gnt_id
);

    always_comb begin
        gnt_vld = req_l | req_d | req_f;
        gnt_id  = ID_L;
        if (req_l) begin
            gnt_id = ID_L;
        end else if (req_d && req_f) begin
            gnt_id = last_d ? ID_F : ID_D;
        end else if (req_d) begin
            gnt_id = ID_D;
        end else if (req_f) begin
            gnt_id = ID_F;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Three-requester memory arbiter: one access per IDLE -> ISSUE -> DONE pass,
// with a registered one-cycle ack and read data presented after DONE.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    state_t            state_q, state_d;
    logic              gnt_vld;
    req_id_t           gnt_id;
    logic              last_d_q;
    logic              latch_en, done_en;
    logic              wen, we_sel, we_q;
    logic [ADDR_W-1:0] addr_sel, addr_q;
    logic [DATA_W-1:0] wdata_sel, wdata_q, din, rdata_q;
    req_id_t           id_q;
    logic [2:0]        ack_q;

    mem_arb_pick u_pick (
        .req_l   (bus.reqL),
        .req_d   (bus.reqD),
        .req_f   (bus.reqF),
        .last_d  (last_d_q),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id)
    );

    always_comb begin
        addr_sel  = bus.addrL;
        wdata_sel = bus.wdataL;
        we_sel    = bus.weL;
        case (gnt_id)
            ID_D: begin
                addr_sel  = bus.addrD;
                wdata_sel = bus.wdataD;
                we_sel    = bus.weD;
            end
            ID_F: begin
                addr_sel  = bus.addrF;
                wdata_sel = bus.wdataF;
                we_sel    = bus.weF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Requests are only looked at in IDLE; ISSUE and DONE run unconditionally
    always_comb begin
        state_d  = state_q;
        latch_en = 1'b0;
        done_en  = 1'b0;
        wen      = 1'b0;
        din      = '0;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    latch_en = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                wen     = we_q;
                din     = wdata_q;
                state_d = DONE;
            end
            DONE: begin
                done_en = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            id_q    <= ID_L;
        end else if (latch_en) begin
            addr_q  <= addr_sel;
            wdata_q <= wdata_sel;
            we_q    <= we_sel;
            id_q    <= gnt_id;
        end
    end

    // Memory data is valid during DONE, so it is captured together with the ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q    <= 3'b000;
            rdata_q  <= '0;
            last_d_q <= 1'b0;
        end else begin
            ack_q <= done_en ? id_onehot(id_q) : 3'b000;
            if (done_en && !we_q) rdata_q <= bus.dataOutVirt;
            if (done_en && id_q == ID_D) last_d_q <= 1'b1;
            else if (done_en && id_q == ID_F) last_d_q <= 1'b0;
        end
    end

    assign bus.ackL        = ack_q[0];
    assign bus.ackD        = ack_q[1];
    assign bus.ackF        = ack_q[2];
    assign bus.rdata       = rdata_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.addressVirt = addr_q;
    assign bus.dataInVirt  = din;
    assign bus.wEnVirt     = wen;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, checked by a
// cycle-level reference model feeding a scoreboard monitor.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic        req_r   [3];
    logic [31:0] addr_r  [3];
    logic [31:0] wdata_r [3];
    logic        we_r    [3];

    assign bus.reqL = req_r[0];  assign bus.addrL = addr_r[0];
    assign bus.reqD = req_r[1];  assign bus.addrD = addr_r[1];
    assign bus.reqF = req_r[2];  assign bus.addrF = addr_r[2];
    assign bus.wdataL = wdata_r[0]; assign bus.weL = we_r[0];
    assign bus.wdataD = wdata_r[1]; assign bus.weD = we_r[1];
    assign bus.wdataF = wdata_r[2]; assign bus.weF = we_r[2];

    logic [2:0] ack_v;
    assign ack_v = {bus.ackF, bus.ackD, bus.ackL};

    function automatic logic [31:0] dflt(input int i);
        return (i == 4) ? 32'hDEAD_BEEF : (32'h1357_0000 + i * 32'h0001_0203);
    endfunction

    // Memory controller: write on wEnVirt, read data one cycle after address
    bit [31:0] mem [64];
    bit        wr_v [64];
    always @(posedge clk) begin
        if (bus.wEnVirt) begin
            mem[bus.addressVirt[7:2]]  <= bus.dataInVirt;
            wr_v[bus.addressVirt[7:2]] <= 1'b1;
        end
        bus.dataOutVirt <= wr_v[bus.addressVirt[7:2]] ? mem[bus.addressVirt[7:2]]
                                                       : dflt(int'(bus.addressVirt[7:2]));
    end

    typedef struct {
        int          cyc;
        int          id;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
    } acc_t;

    acc_t iss_q [$];
    acc_t ack_q [$];
    int   cyc = 0;
    int   next_free = 0;
    bit   last_d = 1'b0;
    int   busy_lo = 0;
    int   busy_hi = -1;
    int   vectors = 0;
    int   miscompares = 0;
    bit [31:0] ref_mem [64];
    bit        ref_v [64];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: an access starts on any edge at least 3 cycles after
    // the previous start; address phase that cycle, ack two cycles later.
    initial begin
        acc_t a;
        int   w;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst) begin
                iss_q.delete();
                ack_q.delete();
                next_free = 0;
                last_d    = 1'b0;
                busy_hi   = -1;
            end else if (cyc >= next_free && (req_r[0] || req_r[1] || req_r[2])) begin
                if (req_r[0])                 w = 0;
                else if (req_r[1] && req_r[2]) w = last_d ? 2 : 1;
                else                          w = req_r[1] ? 1 : 2;
                a = '{cyc, w, addr_r[w], wdata_r[w], we_r[w]};
                iss_q.push_back(a);
                a.cyc = cyc + 2;
                ack_q.push_back(a);
                if (w == 1) last_d = 1'b1;
                else if (w == 2) last_d = 1'b0;
                next_free = cyc + 3;
                busy_lo   = cyc;
                busy_hi   = cyc + 1;
            end
        end
    end

    // Scoreboard monitor
    initial begin
        acc_t        a;
        logic [31:0] last_rd = '0;
        logic [31:0] last_addr = '0;
        logic [31:0] exp_rd;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_ack",   ack_v, 3'b000);
                chk("rst_wen",   bus.wEnVirt, 1'b0);
                chk("rst_din",   bus.dataInVirt, 32'h0);
                chk("rst_addr",  bus.addressVirt, 32'h0);
                chk("rst_rdata", bus.rdata, 32'h0);
                chk("rst_busy",  bus.busy, 1'b0);
                last_rd   = '0;
                last_addr = '0;
            end else begin
                while (iss_q.size() > 0 && iss_q[0].cyc < cyc) begin
                    vectors++; miscompares++;
                    $display("FAIL issue_missing: expected at cycle %0d, now %0d", iss_q[0].cyc, cyc);
                    void'(iss_q.pop_front());
                end
                if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
                    a = iss_q.pop_front();
                    chk("issue_addr", bus.addressVirt, a.addr);
                    chk("issue_wen",  bus.wEnVirt, a.we);
                    chk("issue_din",  bus.dataInVirt, a.wdata);
                    last_addr = a.addr;
                    if (a.we) begin
                        ref_mem[a.addr[7:2]] = a.wdata;
                        ref_v[a.addr[7:2]]   = 1'b1;
                    end
                end else begin
                    chk("idle_wen",  bus.wEnVirt, 1'b0);
                    chk("idle_din",  bus.dataInVirt, 32'h0);
                    chk("hold_addr", bus.addressVirt, last_addr);
                end
                chk("busy", bus.busy, (cyc >= busy_lo && cyc <= busy_hi));
                while (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
                    vectors++; miscompares++;
                    $display("FAIL ack_missing: expected at cycle %0d, now %0d", ack_q[0].cyc, cyc);
                    void'(ack_q.pop_front());
                end
                if (ack_q.size() > 0 && ack_q[0].cyc == cyc) begin
                    a = ack_q.pop_front();
                    chk("ack_who", ack_v, 3'b001 << a.id);
                    if (!a.we) begin
                        exp_rd  = ref_v[a.addr[7:2]] ? ref_mem[a.addr[7:2]] : dflt(int'(a.addr[7:2]));
                        last_rd = exp_rd;
                    end
                end else begin
                    chk("no_ack", ack_v, 3'b000);
                end
                chk("rdata", bus.rdata, last_rd);
            end
        end
    end

    task automatic new_req(input int r);
        req_r[r]   = 1'b1;
        addr_r[r]  = $urandom & 32'hF000_00FC;
        wdata_r[r] = $urandom;
        we_r[r]    = 1'($urandom_range(0, 1));
    endtask

    task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] d, input logic w);
        req_r[r] = 1'b1; addr_r[r] = a; wdata_r[r] = d; we_r[r] = w;
    endtask

    // One negedge step of requester behaviour: hold until ack, then either
    // re-request (always, when held) or go quiet
    task automatic drive_step(input bit [2:0] en, input bit [2:0] hold);
        for (int r = 0; r < 3; r++) begin
            if (en[r]) begin
                if (req_r[r] && ack_v[r]) begin
                    if (hold[r] || $urandom_range(0, 1) == 1) new_req(r);
                    else req_r[r] = 1'b0;
                end else if (!req_r[r] && !hold[r] && $urandom_range(0, 3) == 0) begin
                    new_req(r);
                end
            end
        end
    endtask

    task automatic wait_ack(input int r, input string nm);
        bit got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            if (ack_v[r]) got = 1'b1;
        end
        req_r[r] = 1'b0;
        if (!got) begin
            vectors++; miscompares++;
            $display("FAIL %s: no ack from requester %0d within 12 cycles", nm, r);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (ack_q.size() > 0 || iss_q.size() > 0); i++) @(negedge clk);
        if (ack_q.size() > 0) begin
            vectors++; miscompares++;
            $display("FAIL drain: %0d acks still outstanding", ack_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b0;
        repeat (n) @(negedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < 3; r++) begin
            req_r[r] = 1'b0; addr_r[r] = '0; wdata_r[r] = '0; we_r[r] = 1'b0;
        end
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;

        // Single read from the fetch port
        @(negedge clk);
        set_req(2, 32'h0000_0010, 32'h0, 1'b0);
        wait_ack(2, "single_read");
        chk("read_deadbeef", bus.rdata, 32'hDEAD_BEEF);

        // Single write from the data port; rdata must keep the read value
        @(negedge clk);
        set_req(1, 32'h1000_0004, 32'h55, 1'b1);
        wait_ack(1, "single_write");
        chk("write_keeps_rdata", bus.rdata, 32'hDEAD_BEEF);
        drain();

        // F rises during D's ISSUE cycle
        @(negedge clk);
        set_req(1, 32'h0000_0004, 32'h0, 1'b0);
        @(negedge clk);
        set_req(2, 32'h1000_0004, 32'h0, 1'b0);
        wait_ack(1, "late_d");
        wait_ack(2, "late_f");
        drain();

        // F drops req right after being granted; ack still arrives
        @(negedge clk);
        set_req(2, 32'h2000_0020, 32'h0, 1'b0);
        @(negedge clk);
        req_r[2] = 1'b0;
        wait_ack(2, "early_drop");
        drain();

        // D and F held from reset: D first, then alternate
        @(negedge clk);
        rst = 1'b0;
        set_req(1, 32'h0000_0008, 32'h0, 1'b0);
        set_req(2, 32'h0000_000C, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        repeat (14) begin @(negedge clk); drive_step(3'b110, 3'b110); end
        req_r[1] = 1'b0; req_r[2] = 1'b0;
        drain();

        // All three held: L monopolises, then D/F alternate once L drops
        @(negedge clk);
        new_req(0); new_req(1); new_req(2);
        repeat (12) begin @(negedge clk); drive_step(3'b111, 3'b111); end
        req_r[0] = 1'b0;
        repeat (12) begin @(negedge clk); drive_step(3'b110, 3'b110); end
        req_r[1] = 1'b0; req_r[2] = 1'b0;
        drain();

        // Reset asserted during the ISSUE cycle of a write
        @(negedge clk);
        set_req(1, 32'h0000_0020, 32'h1234_5678, 1'b1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_wen",  bus.wEnVirt, 1'b0);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_ack",  ack_v, 3'b000);
        req_r[1] = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        set_req(1, 32'h0000_0020, 32'h0, 1'b0);
        wait_ack(1, "after_abort");
        drain();

        // Random traffic
        repeat (1500) begin @(negedge clk); drive_step(3'b111, 3'b000); end
        @(negedge clk);
        req_r[0] = 1'b0; req_r[1] = 1'b0; req_r[2] = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
